// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, reads the combinational
// instruction memory and fills the IF/ID register. Handles decode stalls,
// flushes and redirects. A misaligned or out-of-range PC halts fetch in a
// sticky FAULT state until a redirect arrives.
module fetch_stage #(
   parameter int n = 32,
   parameter int r = 6,
   parameter logic [n-1:0] RESET_PC = '0
) (
   input  logic         clk,
   input  logic         reset,
   output logic [r-1:0] imem_addr,
   input  logic [n-1:0] imem_rdata,
   input  logic         stall_d,
   input  logic         flush_d,
   input  logic         redirect_valid,
   input  logic [n-1:0] redirect_pc,
   output logic [n-1:0] pc_f,
   output logic [n-1:0] instr_d,
   output logic [n-1:0] pc_d,
   output logic [n-1:0] pcplus4_d,
   output logic         valid_d,
   output logic         fault,
   output logic [31:0]  fetch_count
);

   typedef enum logic [0:0] {RUN, FAULT} state_t;

   state_t      state, state_n;
   logic [n-1:0] pc_n, instr_n, pcd_n, pcp4_n;
   logic         valid_n;
   logic [31:0]  count_n;
   logic [n-1:0] pc_plus4;
   logic         pc_good;

   // The PC is usable only when word-aligned and inside the memory's byte range;
   // pc_f + 4 wraps naturally at 2**n.
   assign pc_plus4  = pc_f + n'(4);
   assign pc_good   = (pc_f[1:0] == 2'b00) && (pc_f[n-1:r+2] == '0);
   assign imem_addr = pc_f[r+1:2];
   assign fault     = (state == FAULT);

   // Next-state and next-register values, in priority order:
   // redirect, FAULT hold, stall, bad-PC trap, normal advance.
   always_comb begin
      state_n = state;
      pc_n    = pc_f;
      instr_n = instr_d;
      pcd_n   = pc_d;
      pcp4_n  = pcplus4_d;
      valid_n = valid_d;
      count_n = fetch_count;
      if (redirect_valid) begin
         pc_n    = redirect_pc;
         valid_n = 1'b0;
         state_n = RUN;
      end else if (state == FAULT) begin
         valid_n = 1'b0;
      end else if (stall_d) begin
         if (flush_d) begin
            valid_n = 1'b0;
         end
      end else if (!pc_good) begin
         valid_n = 1'b0;
         state_n = FAULT;
      end else begin
         instr_n = imem_rdata;
         pcd_n   = pc_f;
         pcp4_n  = pc_plus4;
         pc_n    = pc_plus4;
         valid_n = !flush_d;
         if (!flush_d) begin
            count_n = fetch_count + 32'd1;
         end
      end
   end

   // State, PC and IF/ID registers with synchronous reset taking priority
   // over everything else on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pc_f        <= RESET_PC;
         instr_d     <= '0;
         pc_d        <= '0;
         pcplus4_d   <= '0;
         valid_d     <= 1'b0;
         fetch_count <= 32'd0;
      end else begin
         state       <= state_n;
         pc_f        <= pc_n;
         instr_d     <= instr_n;
         pc_d        <= pcd_n;
         pcplus4_d   <= pcp4_n;
         valid_d     <= valid_n;
         fetch_count <= count_n;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a 64-word behavioural instruction memory.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [5:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        stall_d;
   logic        flush_d;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pcplus4_d;
   logic        valid_d;
   logic        fault;
   logic [31:0] fetch_count;

   logic [31:0] mem [0:63];
   int checks = 0;
   int errors = 0;

   fetch_stage #(.n(32), .r(6), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .stall_d(stall_d), .flush_d(flush_d), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
      .pcplus4_d(pcplus4_d), .valid_d(valid_d), .fault(fault), .fetch_count(fetch_count)
   );

   assign imem_rdata = mem[imem_addr];

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      tick();
      tick();
      checks++; if (pc_f !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc actual=%h expected=%h", pc_f, 32'h0); end
      checks++; if (instr_d !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr actual=%h expected=%h", instr_d, 32'h0); end
      checks++; if (pc_d !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_d actual=%h expected=%h", pc_d, 32'h0); end
      checks++; if (pcplus4_d !== 32'h0) begin errors++; $display("[TB] FAIL reset_pcplus4 actual=%h expected=%h", pcplus4_d, 32'h0); end
      checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid actual=%b expected=0", valid_d); end
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault actual=%b expected=0", fault); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count actual=%0d expected=0", fetch_count); end
      checks++; if (imem_addr !== 6'd0) begin errors++; $display("[TB] FAIL reset_imem_addr actual=%0d expected=0", imem_addr); end
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++; if (instr_d !== 32'(k * 17)) begin errors++; $display("[TB] FAIL seq_instr%0d actual=%h expected=%h", k, instr_d, 32'(k * 17)); end
         checks++; if (pc_d !== 32'(4 * (k - 1))) begin errors++; $display("[TB] FAIL seq_pc_d%0d actual=%h expected=%h", k, pc_d, 32'(4 * (k - 1))); end
         checks++; if (valid_d !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid%0d actual=%b expected=1", k, valid_d); end
      end
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL seq_count actual=%0d expected=4", fetch_count); end
      checks++; if (pc_f !== 32'h10) begin errors++; $display("[TB] FAIL seq_pc_f actual=%h expected=%h", pc_f, 32'h10); end
      checks++; if (pcplus4_d !== 32'h10) begin errors++; $display("[TB] FAIL seq_pcplus4 actual=%h expected=%h", pcplus4_d, 32'h10); end
   endtask

   task automatic test_stall();
      do_reset();
      tick();
      tick();
      checks++; if (instr_d !== 32'h22) begin errors++; $display("[TB] FAIL stall_pre_instr actual=%h expected=%h", instr_d, 32'h22); end
      checks++; if (imem_addr !== 6'd2) begin errors++; $display("[TB] FAIL stall_imem_addr actual=%0d expected=2", imem_addr); end
      stall_d = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (pc_f !== 32'h8) begin errors++; $display("[TB] FAIL stall_pc%0d actual=%h expected=%h", k, pc_f, 32'h8); end
         checks++; if (instr_d !== 32'h22) begin errors++; $display("[TB] FAIL stall_instr%0d actual=%h expected=%h", k, instr_d, 32'h22); end
         checks++; if (valid_d !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid%0d actual=%b expected=1", k, valid_d); end
      end
      stall_d = 1'b0;
      tick();
      checks++; if (instr_d !== 32'h33) begin errors++; $display("[TB] FAIL stall_post_instr actual=%h expected=%h", instr_d, 32'h33); end
      checks++; if (pc_d !== 32'h8) begin errors++; $display("[TB] FAIL stall_post_pc_d actual=%h expected=%h", pc_d, 32'h8); end
      checks++; if (fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL stall_count actual=%0d expected=3", fetch_count); end
   endtask

   task automatic test_redirect_stall();
      stall_d = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
      tick();
      checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid actual=%b expected=0", valid_d); end
      checks++; if (pc_f !== 32'h20) begin errors++; $display("[TB] FAIL redir_pc_f actual=%h expected=%h", pc_f, 32'h20); end
      checks++; if (instr_d !== 32'h33) begin errors++; $display("[TB] FAIL redir_instr_hold actual=%h expected=%h", instr_d, 32'h33); end
      redirect_valid = 1'b0;
      tick();
      checks++; if (pc_f !== 32'h20) begin errors++; $display("[TB] FAIL redir_stalled_pc actual=%h expected=%h", pc_f, 32'h20); end
      stall_d = 1'b0;
      tick();
      checks++; if (pc_d !== 32'h20) begin errors++; $display("[TB] FAIL redir_pc_d actual=%h expected=%h", pc_d, 32'h20); end
      checks++; if (pcplus4_d !== 32'h24) begin errors++; $display("[TB] FAIL redir_pcplus4 actual=%h expected=%h", pcplus4_d, 32'h24); end
      checks++; if (instr_d !== 32'hC0DE0008) begin errors++; $display("[TB] FAIL redir_instr actual=%h expected=%h", instr_d, 32'hC0DE0008); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("[TB] FAIL redir_valid_after actual=%b expected=1", valid_d); end
      checks++; if (fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL redir_count actual=%0d expected=4", fetch_count); end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_pc = 32'h22;
      tick();
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL misal_fault_early actual=%b expected=0", fault); end
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL misal_fault%0d actual=%b expected=1", k, fault); end
         checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL misal_valid%0d actual=%b expected=0", k, valid_d); end
         checks++; if (pc_f !== 32'h22) begin errors++; $display("[TB] FAIL misal_pc%0d actual=%h expected=%h", k, pc_f, 32'h22); end
         checks++; if (fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL misal_count%0d actual=%0d expected=4", k, fetch_count); end
      end
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      tick();
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL misal_clear actual=%b expected=0", fault); end
      checks++; if (pc_f !== 32'h10) begin errors++; $display("[TB] FAIL misal_newpc actual=%h expected=%h", pc_f, 32'h10); end
      redirect_valid = 1'b0;
      tick();
      checks++; if (instr_d !== 32'hC0DE0004) begin errors++; $display("[TB] FAIL misal_resume_instr actual=%h expected=%h", instr_d, 32'hC0DE0004); end
      checks++; if (pc_d !== 32'h10) begin errors++; $display("[TB] FAIL misal_resume_pc_d actual=%h expected=%h", pc_d, 32'h10); end
      checks++; if (fetch_count !== 32'd5) begin errors++; $display("[TB] FAIL misal_resume_count actual=%0d expected=5", fetch_count); end
   endtask

   task automatic test_end_of_memory();
      redirect_valid = 1'b1; redirect_pc = 32'hF8;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++; if (pc_d !== 32'hF8) begin errors++; $display("[TB] FAIL eom_pc_d0 actual=%h expected=%h", pc_d, 32'hF8); end
      checks++; if (instr_d !== 32'hC0DE003E) begin errors++; $display("[TB] FAIL eom_instr0 actual=%h expected=%h", instr_d, 32'hC0DE003E); end
      tick();
      checks++; if (pc_d !== 32'hFC) begin errors++; $display("[TB] FAIL eom_pc_d1 actual=%h expected=%h", pc_d, 32'hFC); end
      checks++; if (instr_d !== 32'hC0DE003F) begin errors++; $display("[TB] FAIL eom_instr1 actual=%h expected=%h", instr_d, 32'hC0DE003F); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("[TB] FAIL eom_valid1 actual=%b expected=1", valid_d); end
      checks++; if (pc_f !== 32'h100) begin errors++; $display("[TB] FAIL eom_pc_f actual=%h expected=%h", pc_f, 32'h100); end
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL eom_fault_early actual=%b expected=0", fault); end
      tick();
      checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL eom_fault actual=%b expected=1", fault); end
      checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL eom_valid actual=%b expected=0", valid_d); end
      checks++; if (pc_f !== 32'h100) begin errors++; $display("[TB] FAIL eom_pc_hold actual=%h expected=%h", pc_f, 32'h100); end
      checks++; if (fetch_count !== 32'd7) begin errors++; $display("[TB] FAIL eom_count actual=%0d expected=7", fetch_count); end
   endtask

   task automatic test_flush();
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect_valid = 1'b0; flush_d = 1'b1;
      tick();
      checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid actual=%b expected=0", valid_d); end
      checks++; if (pc_f !== 32'h4) begin errors++; $display("[TB] FAIL flush_pc_f actual=%h expected=%h", pc_f, 32'h4); end
      checks++; if (fetch_count !== 32'd7) begin errors++; $display("[TB] FAIL flush_count actual=%0d expected=7", fetch_count); end
      flush_d = 1'b0;
      tick();
      checks++; if (instr_d !== 32'h22) begin errors++; $display("[TB] FAIL flush_next_instr actual=%h expected=%h", instr_d, 32'h22); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("[TB] FAIL flush_next_valid actual=%b expected=1", valid_d); end
      checks++; if (fetch_count !== 32'd8) begin errors++; $display("[TB] FAIL flush_next_count actual=%0d expected=8", fetch_count); end
      stall_d = 1'b1; flush_d = 1'b1;
      tick();
      checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL sflush_valid actual=%b expected=0", valid_d); end
      checks++; if (pc_f !== 32'h8) begin errors++; $display("[TB] FAIL sflush_pc_f actual=%h expected=%h", pc_f, 32'h8); end
      checks++; if (instr_d !== 32'h22) begin errors++; $display("[TB] FAIL sflush_instr actual=%h expected=%h", instr_d, 32'h22); end
      stall_d = 1'b0; flush_d = 1'b0;
      tick();
      checks++; if (instr_d !== 32'h33) begin errors++; $display("[TB] FAIL sflush_next_instr actual=%h expected=%h", instr_d, 32'h33); end
      checks++; if (fetch_count !== 32'd9) begin errors++; $display("[TB] FAIL sflush_next_count actual=%0d expected=9", fetch_count); end
   endtask

   task automatic test_reset_midstream();
      redirect_valid = 1'b1; redirect_pc = 32'h3;
      tick();
      redirect_valid = 1'b0;
      tick();
      checks++; if (fault !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_fault actual=%b expected=1", fault); end
      reset = 1'b1; stall_d = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      tick();
      checks++; if (pc_f !== 32'h0) begin errors++; $display("[TB] FAIL midf_pc_f actual=%h expected=%h", pc_f, 32'h0); end
      checks++; if (fault !== 1'b0) begin errors++; $display("[TB] FAIL midf_fault actual=%b expected=0", fault); end
      checks++; if (instr_d !== 32'h0) begin errors++; $display("[TB] FAIL midf_instr actual=%h expected=%h", instr_d, 32'h0); end
      checks++; if (pc_d !== 32'h0) begin errors++; $display("[TB] FAIL midf_pc_d actual=%h expected=%h", pc_d, 32'h0); end
      checks++; if (pcplus4_d !== 32'h0) begin errors++; $display("[TB] FAIL midf_pcplus4 actual=%h expected=%h", pcplus4_d, 32'h0); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL midf_count actual=%0d expected=0", fetch_count); end
      reset = 1'b0; stall_d = 1'b0; redirect_valid = 1'b0;
      tick();
      tick();
      checks++; if (instr_d !== 32'h22) begin errors++; $display("[TB] FAIL mids_pre_instr actual=%h expected=%h", instr_d, 32'h22); end
      stall_d = 1'b1; reset = 1'b1;
      tick();
      checks++; if (pc_f !== 32'h0) begin errors++; $display("[TB] FAIL mids_pc_f actual=%h expected=%h", pc_f, 32'h0); end
      checks++; if (instr_d !== 32'h0) begin errors++; $display("[TB] FAIL mids_instr actual=%h expected=%h", instr_d, 32'h0); end
      checks++; if (valid_d !== 1'b0) begin errors++; $display("[TB] FAIL mids_valid actual=%b expected=0", valid_d); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL mids_count actual=%0d expected=0", fetch_count); end
      reset = 1'b0; stall_d = 1'b0;
      tick();
      checks++; if (instr_d !== 32'h11) begin errors++; $display("[TB] FAIL mids_first_instr actual=%h expected=%h", instr_d, 32'h11); end
      checks++; if (valid_d !== 1'b1) begin errors++; $display("[TB] FAIL mids_first_valid actual=%b expected=1", valid_d); end
   endtask

   // Test sequence: memory image, then each scenario in turn, then the summary.
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 + 32'(i);
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      reset = 1'b1; stall_d = 1'b0; flush_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      $display("[TB] starting fetch_stage tests");
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_stall();
      test_misaligned();
      test_end_of_memory();
      test_flush();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the single-issue pipeline. It owns the fetch program counter and drives the word address into the combinational instruction memory. It captures the returned instruction word into the IF/ID pipeline register for decode. It also handles decode stalls, branch/jump redirects and flushes, and traps fetches from misaligned or out-of-range PCs.

## Interface
- `n`, default 32: data and PC width in bits.
- `r`, default 6: instruction-memory word-address width; memory holds 2**r words.
- `RESET_PC`, default 0: byte address loaded into the PC on reset.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset. Sampled on `clk` only.
- `imem_addr`  out  r  word address to instruction memory. Equals `pc_f[r+1:2]`; combinational from `pc_f`.
- `imem_rdata`  in  n  instruction word returned combinationally for `imem_addr`.
- `stall_d`  in  1  decode cannot accept; hold PC and IF/ID.
- `flush_d`  in  1  squash the IF/ID contents (insert a bubble).
- `redirect_valid`  in  1  taken branch or jump this cycle.
- `redirect_pc`  in  n  byte target of the redirect.
- `pc_f`  out  n  current fetch PC (registered).
- `instr_d`  out  n  IF/ID instruction.
- `pc_d`  out  n  IF/ID PC of `instr_d`.
- `pcplus4_d`  out  n  IF/ID value of `pc_d + 4`.
- `valid_d`  out  1  IF/ID holds a real instruction.
- `fault`  out  1  fetch halted on a bad PC (registered, sticky).
- `fetch_count`  out  32  number of instructions delivered into IF/ID.

## Operation
- The PC is a byte address.
  - It is good when `pc_f[1:0]==0` and `pc_f[n-1:r+2]==0`.
  - `pc_f + 4` is computed modulo 2**n.
- FSM has two states, RUN and FAULT. Reset enters RUN.
- Per-edge priority: `reset` > `redirect_valid` > FAULT hold > `stall_d` > normal advance.
- `reset`:
  - `pc_f` = `RESET_PC`.
  - `instr_d`, `pc_d`, `pcplus4_d` = 0.
  - `valid_d`, `fault` = 0.
  - `fetch_count` = 0.
  - State = RUN.
- `redirect_valid` (either state, regardless of `stall_d`):
  - `pc_f` <= `redirect_pc`.
  - `valid_d` <= 0.
  - State <= RUN, `fault` <= 0.
  - `instr_d`, `pc_d`, `pcplus4_d` hold.
- FAULT, no redirect:
  - `pc_f` holds.
  - `valid_d` <= 0, `fault` stays 1.
  - `fetch_count` holds.
- RUN, `stall_d`=1, no redirect:
  - `pc_f` and all IF/ID fields hold.
  - If `flush_d`=1, `valid_d` <= 0.
- RUN, `stall_d`=0, no redirect, PC bad:
  - `valid_d` <= 0.
  - State <= FAULT, `fault` <= 1.
  - `pc_f` holds.
- RUN, `stall_d`=0, no redirect, PC good:
  - `instr_d` <= `imem_rdata`.
  - `pc_d` <= `pc_f`, `pcplus4_d` <= `pc_f + 4`.
  - `pc_f` <= `pc_f + 4`.
  - `valid_d` <= `!flush_d`.
  - `fetch_count` increments only when `flush_d`=0.
- `fetch_count` wraps from 2**32-1 to 0.
- A redirect to a bad PC is accepted. FAULT is entered on the following non-stalled edge.
- Running sequentially past the last word (PC 4*2**r-4) reaches PC 4*2**r, which faults. Fetch never silently wraps to word 0.

## Timing
- Memory read is zero-cycle: `imem_addr` changes in the same cycle as `pc_f`.
- IF/ID latency is 1 edge: the instruction at `pc_f` during cycle k appears on `instr_d` after edge k.
- Redirect penalty:
  - The edge that takes the redirect produces one bubble.
  - The target instruction appears on `instr_d` after the next unstalled edge.
- `stall_d` held for N cycles freezes `pc_f`/IF/ID for exactly N edges, with no lost or duplicated instruction.
- `fault` rises on the edge after the unstalled cycle in which the bad PC was presented. It clears on the redirect edge.
- Reset asserted mid-stream overrides stall, redirect and FAULT on that edge.
- First fetch: `RESET_PC`'s instruction is valid on `instr_d` after the first edge following reset release.

## Test plan
- Reset release, memory words 0..3 = 0x11,0x22,0x33,0x44, no stall:
  - `instr_d` sequence 0x11,0x22,0x33,0x44.
  - `pc_d` sequence 0,4,8,0xC.
  - `valid_d`=1 from edge 1.
  - `fetch_count`=4.
- `stall_d`=1 for 3 cycles while `instr_d`=0x22:
  - `pc_f` stays 8 and `instr_d` stays 0x22.
  - Next edge gives 0x33 with no repeat or skip.
- Redirect to 0x20 while `stall_d`=1:
  - `valid_d`=0 next edge.
  - `pc_f`=0x20.
  - Next unstalled edge gives `pc_d`=0x20, `pcplus4_d`=0x24.
- Redirect to 0x22:
  - One edge later `fault`=1, `valid_d`=0, `pc_f` stays 0x22, `fetch_count` frozen.
  - Redirect to 0x10 clears `fault`, and fetch resumes at 0x10.
- With r=6, run sequentially from 0xF8:
  - Instructions at 0xF8 and 0xFC are delivered.
  - `pc_f`=0x100 then raises `fault`.
- `flush_d` without stall:
  - `valid_d`=0 and `fetch_count` unchanged.
  - `pc_f` still advances by 4.
- Reset asserted mid-FAULT or mid-stall:
  - All outputs reach their reset values on that edge.
  - `pc_f`=`RESET_PC`.
